// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch / program-counter controller: fetches from imem, holds the instruction
// for the datapath, resolves branches and jumps, and stops on EBREAK or a misaligned target.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch,
    input  logic        jump,
    input  logic        zero,
    input  logic        lt,
    input  logic        ltu,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic        pc_src,
    output logic        trap,
    output logic        halted,
    output logic [31:0] retire_cnt
);

    localparam logic [31:0] Ebreak = 32'h0010_0073;

    typedef enum logic [2:0] {StIdle, StFetch, StExec, StHalt, StTrap} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] retire_q, retire_d;

    logic        cond;
    logic [31:0] next_pc;
    logic        is_ebreak;
    logic        misaligned;

    // Branch condition decoded from funct3 of the held instruction.
    always_comb begin
        cond = 1'b0;
        case (instr_q[14:12])
            3'b000:  cond = zero;
            3'b001:  cond = ~zero;
            3'b100:  cond = lt;
            3'b101:  cond = ~lt;
            3'b110:  cond = ltu;
            3'b111:  cond = ~ltu;
            default: cond = 1'b0;
        endcase
    end

    assign pc_src     = jump | (branch & cond);
    assign next_pc    = pc_src ? target : pc_q + 32'd4;
    assign is_ebreak  = (instr_q == Ebreak);
    assign misaligned = pc_src && (target[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            instr_q  <= 32'h0000_0000;
            retire_q <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            retire_q <= retire_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        retire_d = retire_q;
        case (state_q)
            StIdle: state_d = StFetch;
            StFetch: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                // EBREAK wins over the misaligned-target fault.
                if (exec_done) begin
                    if (is_ebreak) begin
                        retire_d = retire_q + 32'd1;
                        state_d  = StHalt;
                    end else if (misaligned) begin
                        state_d = StTrap;
                    end else begin
                        pc_d     = next_pc;
                        retire_d = retire_q + 32'd1;
                        state_d  = StFetch;
                    end
                end
            end
            StHalt:  state_d = StHalt;
            StTrap:  state_d = StTrap;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        imem_req    = (state_q == StFetch);
        imem_addr   = pc_q;
        instr_valid = (state_q == StExec);
        halted      = (state_q == StHalt);
        trap        = (state_q == StTrap);
        pc          = pc_q;
        instr       = instr_q;
        retire_cnt  = retire_q;
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl: stimulus queues expected fetch addresses and retirement
// records; monitors compare them when the DUT handshakes or completes an instruction.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        branch;
    logic        jump;
    logic        zero;
    logic        lt;
    logic        ltu;
    logic [31:0] target;
    logic [31:0] pc;
    logic        pc_src;
    logic        trap;
    logic        halted;
    logic [31:0] retire_cnt;

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .instr_valid(instr_valid),
        .exec_done  (exec_done),
        .branch     (branch),
        .jump       (jump),
        .zero       (zero),
        .lt         (lt),
        .ltu        (ltu),
        .target     (target),
        .pc         (pc),
        .pc_src     (pc_src),
        .trap       (trap),
        .halted     (halted),
        .retire_cnt (retire_cnt)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] retire;
        logic        src;
    } exec_t;

    exec_t       exp_q[$];
    logic [31:0] fetch_q[$];
    logic [31:0] cur_instr;
    int          checks;
    int          failures;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Fetch handshake monitor.
    always @(negedge clk) begin
        if (!rst && imem_req && imem_ready) begin
            if (fetch_q.size() == 0) check("fetch_unexpected", 32'd1, 32'd0);
            else check("fetch_addr", imem_addr, fetch_q.pop_front());
        end
    end

    // Retirement monitor.
    always @(negedge clk) begin : exec_mon
        exec_t e;
        if (!rst && instr_valid && exec_done) begin
            if (exp_q.size() == 0) begin
                check("exec_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("exec_instr", instr, e.instr);
                check("exec_pc", pc, e.pc);
                check("exec_pc_src", 32'(pc_src), 32'(e.src));
                check("exec_retire", retire_cnt, e.retire);
            end
        end
    end

    task automatic do_fetch(input logic [31:0] data, input logic [31:0] addr, input int delay);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!imem_req) begin
            check("fetch_req_timeout", 32'd0, 32'd1);
            return;
        end
        fetch_q.push_back(addr);
        cur_instr = data;
        for (int i = 0; i < delay; i++) begin
            check("fetch_req_held", 32'(imem_req), 32'd1);
            check("fetch_addr_held", imem_addr, addr);
            @(posedge clk); #1;
        end
        imem_ready = 1'b1;
        imem_rdata = data;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic do_exec(input int hold, input logic br, input logic jp, input logic z,
                           input logic l, input logic lu, input logic [31:0] tgt,
                           input logic exp_src, input logic [31:0] exp_pc,
                           input logic [31:0] exp_retire);
        exec_t e;
        check("exec_valid", 32'(instr_valid), 32'd1);
        branch = br; jump = jp; zero = z; lt = l; ltu = lu; target = tgt;
        exec_done = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("exec_hold_valid", 32'(instr_valid), 32'd1);
            check("exec_hold_pc", pc, exp_pc);
        end
        e.instr  = cur_instr;
        e.pc     = exp_pc;
        e.retire = exp_retire;
        e.src    = exp_src;
        exp_q.push_back(e);
        exec_done = 1'b1;
        @(posedge clk); #1;
        exec_done = 1'b0;
        branch = 1'b0; jump = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0; target = 32'h0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; cur_instr = 32'h0;
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; exec_done = 1'b0;
        branch = 1'b0; jump = 1'b0; zero = 1'b0; lt = 1'b0; ltu = 1'b0; target = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_trap", 32'(trap), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_retire", retire_cnt, 32'h0);
        rst = 1'b0;
        check("req_low_after_rst", 32'(imem_req), 32'd0);
        @(posedge clk); #1;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0);

        // beq taken with a 3-cycle memory stall
        do_fetch(32'h00628c63, 32'h0, 3);
        do_exec(2, 1, 0, 1, 0, 0, 32'h18, 1, 32'h0, 32'd0);
        check("beq_pc", pc, 32'h18);
        check("beq_retire", retire_cnt, 32'd1);
        // bne not taken, then taken
        do_fetch(32'h00629a63, 32'h18, 0);
        do_exec(0, 1, 0, 1, 0, 0, 32'h40, 0, 32'h18, 32'd1);
        do_fetch(32'h00629a63, 32'h1C, 1);
        do_exec(1, 1, 0, 0, 0, 0, 32'h40, 1, 32'h1C, 32'd2);
        // bltu taken, bgeu not taken
        do_fetch(32'h0052e863, 32'h40, 0);
        do_exec(0, 1, 0, 0, 0, 1, 32'h80, 1, 32'h40, 32'd3);
        do_fetch(32'h0062f263, 32'h80, 0);
        do_exec(0, 1, 0, 0, 0, 1, 32'h200, 0, 32'h80, 32'd4);
        // blt with zero also set; funct3=010 never taken
        do_fetch(32'h00004063, 32'h84, 0);
        do_exec(0, 1, 0, 1, 1, 0, 32'h100, 1, 32'h84, 32'd5);
        do_fetch(32'h00002063, 32'h100, 0);
        do_exec(0, 1, 0, 1, 1, 1, 32'h300, 0, 32'h100, 32'd6);
        // jump to the top word, then pc+4 wraps to 0
        do_fetch(32'h0000006f, 32'h104, 0);
        do_exec(0, 0, 1, 0, 0, 0, 32'hFFFF_FFFC, 1, 32'h104, 32'd7);
        do_fetch(32'h00000013, 32'hFFFF_FFFC, 0);
        do_exec(0, 0, 0, 0, 0, 0, 32'h5, 0, 32'hFFFF_FFFC, 32'd8);
        check("wrap_pc", pc, 32'h0);
        // misaligned jump target traps
        do_fetch(32'h0000006f, 32'h0, 0);
        do_exec(0, 0, 1, 0, 0, 0, 32'h1A, 1, 32'h0, 32'd9);
        check("trap_flag", 32'(trap), 32'd1);
        check("trap_halted", 32'(halted), 32'd0);
        check("trap_pc", pc, 32'h0);
        check("trap_retire", retire_cnt, 32'd9);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("trap_no_req", 32'(imem_req), 32'd0);
        end
        check("trap_sticky", 32'(trap), 32'd1);

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("trap_cleared", 32'(trap), 32'd0);
        // EBREAK with a misaligned jump pending: halt wins
        do_fetch(32'h00100073, 32'h0, 1);
        do_exec(0, 0, 1, 0, 0, 0, 32'h1A, 1, 32'h0, 32'd0);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_trap", 32'(trap), 32'd0);
        check("halt_retire", retire_cnt, 32'd1);
        check("halt_pc", pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("halt_no_req", 32'(imem_req), 32'd0);
        end

        // reset during FETCH with ready must not latch data
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("pre_fetch_req", 32'(imem_req), 32'd1);
        imem_ready = 1'b1; imem_rdata = 32'h1234_5678; rst = 1'b1;
        @(posedge clk); #1;
        imem_ready = 1'b0;
        check("rst_fetch_instr", instr, 32'h0);
        check("rst_fetch_req", 32'(imem_req), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // reset during EXEC with exec_done
        do_fetch(32'h00000013, 32'h0, 0);
        do_exec(0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 32'd0);
        do_fetch(32'h00000013, 32'h4, 0);
        exec_done = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        exec_done = 1'b0;
        check("rst_exec_valid", 32'(instr_valid), 32'd0);
        check("rst_exec_pc", pc, 32'h0);
        check("rst_exec_retire", retire_cnt, 32'd0);
        check("rst_exec_req", 32'(imem_req), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_exec_first_req", 32'(imem_req), 32'd1);
        check("rst_exec_first_addr", imem_addr, 32'h0);

        check("exec_queue_empty", 32'(exp_q.size()), 32'd0);
        check("fetch_queue_empty", 32'(fetch_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 32'h0000_0000, the PC loaded on reset.
REQ-002 The block SHALL have a single clock; reset SHALL be synchronous and active-high.
REQ-003 The port list SHALL be, one port per line (name, direction, width, meaning), clock and reset first:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; equals pc.
- imem_ready  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched instruction.
- instr  out  32  latched current instruction.
- instr_valid  out  1  instr is held for datapath execution.
- exec_done  in  1  datapath has finished the current instruction.
- branch  in  1  current instruction is a conditional branch.
- jump  in  1  current instruction is JAL/JALR.
- zero, lt, ltu  in  1 each  ALU compare flags.
- target  in  32  branch/jump target from datapath.
- pc  out  32  current program counter.
- pc_src  out  1  redirect decision (1 = target, 0 = pc+4).
- trap  out  1  misaligned-target fault, sticky.
- halted  out  1  EBREAK retired, sticky.
- retire_cnt  out  32  retired-instruction counter.

Function
REQ-004 The FSM SHALL have states IDLE, FETCH, EXEC, HALT and TRAP.
REQ-005 IDLE SHALL go to FETCH unconditionally on the next cycle.
REQ-006 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc.
REQ-007 imem_req SHALL be 0 in every state other than FETCH.
REQ-008 In FETCH with imem_ready=1, the block SHALL latch imem_rdata into instr and enter EXEC on the next cycle.
REQ-009 In FETCH with imem_ready=0, the block SHALL hold state, address and request (no timeout).
REQ-010 instr_valid SHALL be 1 exactly while in EXEC.
REQ-011 instr SHALL hold its value outside of FETCH-with-ready.
REQ-012 pc_src SHALL be combinational: jump | (branch & cond).
REQ-013 cond SHALL be selected by instr[14:12]:
- 000 -> zero; 001 -> !zero
- 100 -> lt; 101 -> !lt
- 110 -> ltu; 111 -> !ltu
- 010/011 -> 0
REQ-014 pc_src SHALL be evaluated in all states; it SHALL only take effect in EXEC.
REQ-015 next_pc SHALL be target when pc_src=1, else pc+4, computed mod 2^32 (0xFFFF_FFFC+4 wraps to 0).
REQ-016 In EXEC with exec_done=1 and instr==32'h0010_0073 (EBREAK), the block SHALL increment retire_cnt, leave pc unchanged and enter HALT.
REQ-017 In EXEC with exec_done=1, pc_src=1 and target[1:0]!=0, the block SHALL leave pc unchanged, leave retire_cnt unchanged and enter TRAP.
REQ-018 In EXEC with exec_done=1 in all other cases, the block SHALL load pc<=next_pc, increment retire_cnt and enter FETCH.
REQ-019 EBREAK SHALL take priority over the misaligned-target check.
REQ-020 In EXEC with exec_done=0, the block SHALL hold all state; flag changes SHALL affect only the combinational pc_src.
REQ-021 retire_cnt SHALL wrap from 0xFFFF_FFFF to 0.
REQ-022 halted SHALL be 1 exactly in HALT; trap SHALL be 1 exactly in TRAP.
REQ-023 HALT and TRAP SHALL be exited only by rst.

Reset
REQ-024 When rst=1 at a clock edge, the block SHALL load: state=IDLE, pc=RESET_PC, instr=0, retire_cnt=0.
REQ-025 Reset values SHALL give imem_req=0, instr_valid=0, trap=0 and halted=0.
REQ-026 Reset SHALL override every state, including mid-FETCH with imem_ready=1 and mid-EXEC with exec_done=1.
REQ-027 The first imem_req after rst deasserts SHALL occur exactly 1 cycle later, with imem_addr=RESET_PC.

Verification
REQ-028 Scenario: fetch 0x00628c63 at pc=0 with imem_ready delayed 3 cycles, then branch=1, zero=1, target=0x18, exec_done=1 -> imem_req held 3 cycles, pc_src=1, pc=0x18, retire_cnt=1.
REQ-029 Scenario: instr 0x00629a63 at pc=0x18, branch=1, zero=1, exec_done=1 -> pc_src=0, pc=0x1C; then zero=0 on a repeat of the same instruction -> pc_src=1, pc=target.
REQ-030 Scenario: instr 0x0052e863 with ltu=1, then 0x0062f263 with ltu=1, branch=1 for both -> pc_src=1 then 0.
REQ-031 Scenario: jump=1, target=0x1A, exec_done=1 -> TRAP, trap=1, pc unchanged, retire_cnt unchanged, imem_req=0 on all following cycles.
REQ-032 Scenario: imem_rdata=0x00100073, exec_done=1 -> halted=1, retire_cnt incremented, no further imem_req.
REQ-033 Scenario: rst=1 during EXEC with exec_done=1 -> next cycle state=IDLE, pc=RESET_PC, retire_cnt=0; one cycle later imem_req=1 with imem_addr=RESET_PC.
